// File: rtl/vend_dispenser_if.sv
// Request/actuator bundle between the upstream vending FSM and the dispenser.
// The master side issues vend requests and supplies the drop sensor; the slave side drives the actuators.
interface vend_dispenser_if;
   logic       sell;
   logic [1:0] change;
   logic       drop_det;
   logic       motor_en;
   logic       coin_eject;
   logic       busy;
   logic       ovf;
   logic       fault;

   modport master (
      output sell, change, drop_det,
      input  motor_en, coin_eject, busy, ovf, fault
   );

   modport slave (
      input  sell, change, drop_det,
      output motor_en, coin_eject, busy, ovf, fault
   );
endinterface

// File: rtl/vend_dispenser.sv
// Drink/change dispenser: queues vend requests in saturating counters and services them one at a time,
// with drinks taking priority over coins. A motor run without a drop edge locks the block into FAULT.
module vend_dispenser #(
   parameter int unsigned MOTOR_TIMEOUT = 255,
   parameter int unsigned EJECT_CYCLES  = 4
) (
   input  logic             clk,
   input  logic             rstn,
   vend_dispenser_if.slave  bus
);

   localparam int unsigned TMAX = (MOTOR_TIMEOUT > EJECT_CYCLES) ? MOTOR_TIMEOUT : EJECT_CYCLES;
   localparam int          TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam logic [TW-1:0] MOTOR_LAST = TW'(MOTOR_TIMEOUT - 1);
   localparam logic [TW-1:0] EJECT_LAST = TW'(EJECT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MOTOR,
      S_EJECT,
      S_GAP,
      S_FAULT
   } state_e;

   state_e        state_q, state_d;
   logic [1:0]    drk_q, drk_d;
   logic [2:0]    coin_q, coin_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          drop_prev_q;
   logic          motor_en_q, coin_eject_q, busy_q, ovf_q, fault_q;

   logic          drop_edge;
   logic          drk_dec, coin_dec;
   logic [2:0]    drk_sum;
   logic [3:0]    coin_sum;
   logic [1:0]    coin_add;
   logic          drk_ovf, coin_ovf;

   // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      drk_dec   = 1'b0;
      coin_dec  = 1'b0;
      drop_edge = bus.drop_det & ~drop_prev_q;

      unique case (state_q)
         S_IDLE: begin
            timer_d = '0;
            if (drk_q != 2'd0) begin
               state_d = S_MOTOR;
            end else if (coin_q != 3'd0) begin
               state_d = S_EJECT;
            end
         end
         S_MOTOR: begin
            // A drop edge in the timeout cycle still counts as a successful vend.
            if (drop_edge) begin
               drk_dec = 1'b1;
               state_d = S_GAP;
               timer_d = '0;
            end else if (timer_q == MOTOR_LAST) begin
               state_d = S_FAULT;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_EJECT: begin
            if (timer_q == EJECT_LAST) begin
               coin_dec = 1'b1;
               state_d  = S_GAP;
               timer_d  = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_GAP:   state_d = S_IDLE;
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_IDLE;
      endcase

      // Increment and decrement land on the same edge, so saturation is judged on the net value.
      coin_add = bus.sell ? bus.change : 2'd0;
      drk_sum  = {1'b0, drk_q} + {2'b00, bus.sell} - {2'b00, drk_dec};
      coin_sum = {1'b0, coin_q} + {2'b00, coin_add} - {3'b000, coin_dec};
      drk_ovf  = (drk_sum > 3'd3);
      coin_ovf = (coin_sum > 4'd7);
      drk_d    = drk_ovf ? 2'd3 : drk_sum[1:0];
      coin_d   = coin_ovf ? 3'd7 : coin_sum[2:0];
   end

   // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= S_IDLE;
         drk_q        <= 2'd0;
         coin_q       <= 3'd0;
         timer_q      <= '0;
         drop_prev_q  <= 1'b0;
         motor_en_q   <= 1'b0;
         coin_eject_q <= 1'b0;
         busy_q       <= 1'b0;
         ovf_q        <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         drk_q        <= drk_d;
         coin_q       <= coin_d;
         timer_q      <= timer_d;
         drop_prev_q  <= bus.drop_det;
         motor_en_q   <= (state_d == S_MOTOR);
         coin_eject_q <= (state_d == S_EJECT);
         busy_q       <= (state_d != S_IDLE) || (drk_d != 2'd0) || (coin_d != 3'd0);
         ovf_q        <= drk_ovf | coin_ovf;
         fault_q      <= (state_d == S_FAULT);
      end
   end

   assign bus.motor_en   = motor_en_q;
   assign bus.coin_eject = coin_eject_q;
   assign bus.busy       = busy_q;
   assign bus.ovf        = ovf_q;
   assign bus.fault      = fault_q;

endmodule

// File: tb/tb_vend_dispenser.sv
// Bench for vend_dispenser: a request model pushes expected service items, a negedge monitor
// pops them as motor runs and coin pulses complete.
module tb_vend_dispenser;

   localparam int MT = 255;
   localparam int EC = 4;

   typedef enum logic {K_DRINK, K_COIN} kind_e;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   vend_dispenser_if bus_if ();

   vend_dispenser #(
      .MOTOR_TIMEOUT (MT),
      .EJECT_CYCLES  (EC)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus_if)
   );

   kind_e sb_q[$];
   int    n_total = 0;
   int    n_bad   = 0;
   int    drk_model, coin_model, ovf_exp, ovf_seen;
   int    motor_len, last_motor_len, motor_runs, eject_len, gap_len;
   logic  prev_motor, prev_eject, seen_eject;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic sb_pop(input kind_e got);
      kind_e exp;
      if (sb_q.size() == 0) begin
         check("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
         exp = sb_q.pop_front();
         check("sb_kind", 32'(got), 32'(exp));
         if (exp == K_DRINK) drk_model--;
         else                coin_model--;
      end
   endtask

   // Request model: saturating pending counts, expected items and expected ovf pulses.
   task automatic sell_req(input logic [1:0] ch);
      logic ov;
      @(negedge clk);
      bus_if.sell   = 1'b1;
      bus_if.change = ch;
      ov = 1'b0;
      if (drk_model == 3) begin
         ov = 1'b1;
      end else begin
         drk_model++;
         sb_q.push_back(K_DRINK);
      end
      for (int i = 0; i < int'(ch); i++) begin
         if (coin_model == 7) begin
            ov = 1'b1;
         end else begin
            coin_model++;
            sb_q.push_back(K_COIN);
         end
      end
      if (ov) ovf_exp++;
   endtask

   task automatic sell_end();
      @(negedge clk);
      bus_if.sell   = 1'b0;
      bus_if.change = 2'd0;
   endtask

   task automatic wait_motor_hi(input int budget);
      int n = 0;
      while (bus_if.motor_en !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (bus_if.motor_en !== 1'b1) check("motor_start_timeout", 32'(bus_if.motor_en), 32'd1);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (bus_if.busy !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (bus_if.busy !== 1'b0) check("idle_timeout", 32'(bus_if.busy), 32'd0);
   endtask

   task automatic run_drink(input int hold);
      wait_motor_hi(50);
      repeat (hold) @(negedge clk);
      bus_if.drop_det = 1'b1;
      @(negedge clk);
      bus_if.drop_det = 1'b0;
   endtask

   task automatic flush_model();
      sb_q.delete();
      drk_model  = 0;
      coin_model = 0;
      ovf_exp    = 0;
      ovf_seen   = 0;
   endtask

   always @(negedge clk) begin
      if (!rstn) begin
         motor_len  = 0;
         eject_len  = 0;
         gap_len    = 0;
         prev_motor = 1'b0;
         prev_eject = 1'b0;
         seen_eject = 1'b0;
      end else begin
         if (bus_if.motor_en) begin
            if (!prev_motor) motor_runs++;
            motor_len++;
         end else if (prev_motor) begin
            last_motor_len = motor_len;
            motor_len      = 0;
            if (!bus_if.fault) sb_pop(K_DRINK);
         end
         if (bus_if.coin_eject) begin
            if (!prev_eject && seen_eject) check("eject_gap", 32'(gap_len >= 1), 32'd1);
            eject_len++;
         end else if (prev_eject) begin
            check("eject_len", 32'(eject_len), 32'(EC));
            sb_pop(K_COIN);
            eject_len  = 0;
            gap_len    = 1;
            seen_eject = 1'b1;
         end else begin
            gap_len++;
         end
         if (bus_if.ovf) ovf_seen++;
         prev_motor = bus_if.motor_en;
         prev_eject = bus_if.coin_eject;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int runs_before;
      int n;
      motor_runs      = 0;
      last_motor_len  = 0;
      flush_model();
      rstn            = 1'b0;
      bus_if.sell     = 1'b0;
      bus_if.change   = 2'd0;
      bus_if.drop_det = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_motor", 32'(bus_if.motor_en), 32'd0);
      check("rst_eject", 32'(bus_if.coin_eject), 32'd0);
      check("rst_busy",  32'(bus_if.busy), 32'd0);
      check("rst_ovf",   32'(bus_if.ovf), 32'd0);
      check("rst_fault", 32'(bus_if.fault), 32'd0);
      @(negedge clk);
      rstn = 1'b1;

      // Single drink: two-cycle start latency, drop after 10 motor cycles
      sell_req(2'd0);
      sell_end();
      check("lat1_motor", 32'(bus_if.motor_en), 32'd0);
      check("lat1_busy",  32'(bus_if.busy), 32'd1);
      @(negedge clk);
      check("lat2_motor", 32'(bus_if.motor_en), 32'd1);
      repeat (9) @(negedge clk);
      bus_if.drop_det = 1'b1;
      @(negedge clk);
      bus_if.drop_det = 1'b0;
      check("drop_motor_off", 32'(bus_if.motor_en), 32'd0);
      check("gap_busy",       32'(bus_if.busy), 32'd1);
      @(negedge clk);
      check("idle_busy",      32'(bus_if.busy), 32'd0);
      check("run_len",        32'(last_motor_len), 32'd10);

      // Drop edge outside MOTOR is ignored
      bus_if.drop_det = 1'b1;
      @(negedge clk);
      bus_if.drop_det = 1'b0;
      repeat (3) @(negedge clk);
      check("stray_drop_busy",  32'(bus_if.busy), 32'd0);
      check("stray_drop_motor", 32'(bus_if.motor_en), 32'd0);

      // Drink plus two coins of change
      sell_req(2'd2);
      sell_end();
      run_drink(5);
      wait_idle(100);
      check("chg_sb_left",  32'(sb_q.size()), 32'd0);
      check("chg_coin_mdl", 32'(coin_model), 32'd0);

      // Four back-to-back sells: saturation and a single ovf pulse
      flush_model();
      repeat (4) sell_req(2'd0);
      sell_end();
      for (int r = 0; r < 3; r++) run_drink(4);
      wait_idle(50);
      check("sat_ovf_count", 32'(ovf_seen), 32'(ovf_exp));
      check("sat_ovf_exp",   32'(ovf_exp), 32'd1);
      check("sat_sb_left",   32'(sb_q.size()), 32'd0);

      // Motor timeout into FAULT, requests still accumulate
      flush_model();
      sell_req(2'd0);
      sell_end();
      wait_motor_hi(20);
      n = 0;
      while (bus_if.motor_en === 1'b1 && n < MT + 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check("to_len",   32'(last_motor_len), 32'(MT));
      check("to_fault", 32'(bus_if.fault), 32'd1);
      check("to_motor", 32'(bus_if.motor_en), 32'd0);
      runs_before = motor_runs;
      ovf_exp  = 0;
      ovf_seen = 0;
      repeat (3) sell_req(2'd0);
      sell_end();
      repeat (20) @(negedge clk);
      check("flt_busy",  32'(bus_if.busy), 32'd1);
      check("flt_runs",  32'(motor_runs), 32'(runs_before));
      check("flt_eject", 32'(bus_if.coin_eject), 32'd0);
      check("flt_ovf",   32'(ovf_seen), 32'(ovf_exp));
      check("flt_hold",  32'(bus_if.fault), 32'd1);
      rstn = 1'b0;
      flush_model();
      @(negedge clk);
      check("flt_rst_fault", 32'(bus_if.fault), 32'd0);
      check("flt_rst_busy",  32'(bus_if.busy), 32'd0);
      rstn = 1'b1;

      // Drop edge in the exact timeout cycle wins
      sell_req(2'd0);
      sell_end();
      wait_motor_hi(20);
      repeat (MT - 1) @(negedge clk);
      bus_if.drop_det = 1'b1;
      @(negedge clk);
      bus_if.drop_det = 1'b0;
      check("edge_to_motor", 32'(bus_if.motor_en), 32'd0);
      check("edge_to_fault", 32'(bus_if.fault), 32'd0);
      check("edge_to_gap",   32'(bus_if.busy), 32'd1);
      @(negedge clk);
      check("edge_to_idle",  32'(bus_if.busy), 32'd0);
      check("edge_to_len",   32'(last_motor_len), 32'(MT));

      // Reset asserted in the 2nd EJECT cycle
      sell_req(2'd2);
      sell_end();
      run_drink(3);
      n = 0;
      while (bus_if.coin_eject !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ej_started", 32'(bus_if.coin_eject), 32'd1);
      @(negedge clk);
      #1 rstn = 1'b0;
      #1;
      check("ej_rst_eject", 32'(bus_if.coin_eject), 32'd0);
      check("ej_rst_busy",  32'(bus_if.busy), 32'd0);
      check("ej_rst_motor", 32'(bus_if.motor_en), 32'd0);
      flush_model();
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_busy",  32'(bus_if.busy), 32'd0);
      check("post_rst_eject", 32'(bus_if.coin_eject), 32'd0);
      sell_req(2'd0);
      sell_end();
      check("post_rst_lat1", 32'(bus_if.motor_en), 32'd0);
      @(negedge clk);
      check("post_rst_lat2", 32'(bus_if.motor_en), 32'd1);
      run_drink(2);
      wait_idle(20);
      check("post_rst_sb", 32'(sb_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
